bool_equiv_sweep: RTL

- Sequential equivalence checker for N-input Boolean functions.
- Each function is given as a 2^N-bit truth table.
- On start, latches two tables, sweeps every input vector 0..2^N-1 (one per clock), and streams per-vector outputs for a monitor-style print.
- Reports whether the functions are equivalent (or complementary, per mode), the mismatch count and the first mismatching vector.
- Successor of the fixed 2-input expression-pair blocks; used by the team's expression-simplification exercises and benches.

---
 rtl/bool_equiv_sweep.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/bool_equiv_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : bool_equiv_sweep
//  Purpose  : Sequential equivalence checker for two N-input Boolean
//             functions given as 2^N-bit truth tables. On start the tables
//             and mode are latched. Every input vector 0..2^N-1 is then
//             presented, one per clock, so a monitor can print it. When the
//             sweep ends the block reports equivalence (mode 0) or
//             complementarity (mode 1), the mismatch count and the lowest
//             mismatching vector.
//  Ports    : clk_i              rising-edge clock
//             reset_i            asynchronous active-high reset
//             start_i            request a sweep (sampled in IDLE/DONE only)
//             mode_i             0: check a==b, 1: check a==~b
//             func_a_i/func_b_i  truth tables, bit i = f(vec=i)
//             busy_o             sweep in progress
//             done_o             results valid, held until next start
//             equal_o            no mismatch found (valid while done_o)
//             found_o            at least one mismatch seen
//             mismatch_count_o   number of mismatching vectors, 0..2^N
//             first_mismatch_o   lowest mismatching vector (0 if none)
//             vec_valid_o        vec_o/out_a_o/out_b_o valid this cycle
//             vec_o              current vector, vec_o[N-1] is the MSB input
//             out_a_o/out_b_o    func_a[vec] / func_b[vec]
//  Revision : 1.0  initial release
// ============================================================================
module bool_equiv_sweep #(
  parameter int N  = 2,
  parameter int TW = 2**N
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [TW-1:0] func_a_i,
  input  logic [TW-1:0] func_b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          equal_o,
  output logic          found_o,
  output logic [N:0]    mismatch_count_o,
  output logic [N-1:0]  first_mismatch_o,
  output logic          vec_valid_o,
  output logic [N-1:0]  vec_o,
  output logic          out_a_o,
  output logic          out_b_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [N:0] LAST_IDX = (N+1)'(TW - 1);

  state_t        state_q, state_d;
  logic          launch, advance, finish;

  logic [TW-1:0] tab_a_q, tab_b_q;
  logic          mode_q;
  logic [N:0]    idx_q;
  logic [N-1:0]  vec_q;
  logic          out_a_q, out_b_q;
  logic [N:0]    cnt_q;
  logic          found_q;
  logic [N-1:0]  first_q;
  logic          equal_q;

  // Vector about to be presented and its evaluation. On the start edge the
  // live inputs are used so vector 0 appears in the very first SWEEP cycle;
  // afterwards only the latched copies matter.
  logic [N:0]    sel_idx;
  logic [TW-1:0] sel_a, sel_b;
  logic          sel_mode;
  logic          bit_a, bit_b, mismatch;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_SWEEP;
          launch  = 1'b1;
        end
      end
      S_SWEEP: begin
        // idx_q is the vector currently on display; once the last one has
        // been shown the next edge closes the sweep.
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Vector selection and mismatch evaluation
  // --------------------------------------------------------------------------
  always_comb begin
    sel_idx  = launch ? '0 : (idx_q + (N+1)'(1));
    sel_a    = launch ? func_a_i : tab_a_q;
    sel_b    = launch ? func_b_i : tab_b_q;
    sel_mode = launch ? mode_i   : mode_q;
    // TW is exactly 2^N, so the low N index bits address the whole table.
    bit_a    = sel_a[sel_idx[N-1:0]];
    bit_b    = sel_b[sel_idx[N-1:0]];
    mismatch = ((bit_a ^ bit_b) != sel_mode);
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tab_a_q <= '0;
      tab_b_q <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      vec_q   <= '0;
      out_a_q <= 1'b0;
      out_b_q <= 1'b0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      first_q <= '0;
      equal_q <= 1'b0;
    end else begin
      if (launch) begin
        tab_a_q <= func_a_i;
        tab_b_q <= func_b_i;
        mode_q  <= mode_i;
        idx_q   <= '0;
        vec_q   <= '0;
        out_a_q <= bit_a;
        out_b_q <= bit_b;
        // Results restart here; vector 0 is scored on this same edge.
        cnt_q   <= {{N{1'b0}}, mismatch};
        found_q <= mismatch;
        first_q <= '0;
        equal_q <= 1'b0;
      end
      if (advance) begin
        idx_q   <= sel_idx;
        vec_q   <= sel_idx[N-1:0];
        out_a_q <= bit_a;
        out_b_q <= bit_b;
        if (mismatch) begin
          // At most 2^N increments per sweep, which N+1 bits always hold.
          cnt_q <= cnt_q + (N+1)'(1);
          if (!found_q) begin
            found_q <= 1'b1;
            first_q <= sel_idx[N-1:0];
          end
        end
      end
      if (finish) begin
        equal_q <= (cnt_q == '0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy_o           = (state_q == S_SWEEP);
  assign vec_valid_o      = (state_q == S_SWEEP);
  assign done_o           = (state_q == S_DONE);
  assign equal_o          = equal_q;
  assign found_o          = found_q;
  assign mismatch_count_o = cnt_q;
  assign first_mismatch_o = first_q;
  assign vec_o            = vec_q;
  assign out_a_o          = out_a_q;
  assign out_b_o          = out_b_q;

endmodule
`default_nettype wire
